// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss it fetches the whole block one word per
// grant from the memory arbitrator and writes each word into the arrays on return.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           service,
    input  logic                           data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           request,
    output logic [ADDR_W-1:0]              mem_address,
    output logic                           fsm_busy,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_sel,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    localparam int WSEL_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W  = WSEL_W + 1;
    localparam int CNT_W  = $clog2(BLOCK_WORDS + 1);
    localparam int BASE_W = ADDR_W - OFF_W;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state;
    logic [BASE_W-1:0]  base;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   recv_cnt;
    logic               grant;
    logic               recv;
    logic               last_word;
    logic               unused_addr_bits;

    // Handshake: request/service -- a word is issued in any cycle where both are
    // high; until then request stays up and mem_address does not move.
    assign request   = (state == FILL) && (issue_cnt < FULL_CNT);
    assign grant     = request && service;
    assign recv      = (state == FILL) && data_valid && (recv_cnt < issue_cnt);
    assign last_word = recv && (recv_cnt == LAST_CNT);

    assign mem_address      = request ? {base, issue_cnt[WSEL_W-1:0], 1'b0} : '0;
    assign write_data_array = recv;
    assign word_sel         = recv ? recv_cnt[WSEL_W-1:0] : '0;
    assign write_tag_array  = last_word;
    assign fill_data        = rst ? '0 : memory_data;

    // Byte offset within the block is irrelevant to a whole-block fill.
    assign unused_addr_bits = ^miss_address[OFF_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fsm_busy  <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state     <= FILL;
                        fsm_busy  <= 1'b1;
                        base      <= miss_address[ADDR_W-1:OFF_W];
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                    end
                end
                FILL: begin
                    if (grant) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (recv) begin
                        recv_cnt <= recv_cnt + CNT_W'(1);
                    end
                    if (last_word) begin
                        state    <= IDLE;
                        fsm_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    fsm_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a vector table for a basic fill, directed corner
// sequences, and randomized fills against a queue-based reference model.
module tb_cache_fill_fsm;

    localparam int BW = 8;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        service;
    logic        data_valid;
    logic [15:0] memory_data;
    logic        request;
    logic [15:0] mem_address;
    logic        fsm_busy;
    logic        write_data_array;
    logic [2:0]  word_sel;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .service          (service),
        .data_valid       (data_valid),
        .memory_data      (memory_data),
        .request          (request),
        .mem_address      (mem_address),
        .fsm_busy         (fsm_busy),
        .write_data_array (write_data_array),
        .word_sel         (word_sel),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        rst;
        logic        miss;
        logic [15:0] maddr;
        logic        srv;
        logic        dv;
        logic [15:0] mdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_busy;
        logic        e_wr;
        logic [2:0]  e_ws;
        logic        e_tag;
        logic [15:0] e_fd;
    } vec_t;

    vec_t vecs[17];

    // ---------------- memory emulator ----------------
    typedef struct {
        int          due;
        logic [15:0] addr;
    } rd_t;

    rd_t mem_q[$];
    int  lat_lo = 4;
    int  lat_hi = 4;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], ~a[15:8]};
    endfunction

    // ---------------- reference model ----------------
    bit          m_busy = 1'b0;
    logic [15:0] m_base;
    int          m_issued;
    int          m_written;
    logic [15:0] exp_q[$];   // word indices issued but not yet written back
    int          cnt_busy;
    int          cnt_wr;

    task automatic step(input logic r, input logic miss, input logic [15:0] maddr, input logic srv);
        logic        e_req;
        logic        e_wr;
        logic        e_tag;
        logic [15:0] e_addr;
        logic [2:0]  e_ws;
        rd_t         rd;
        rst           = r;
        miss_detected = miss;
        miss_address  = maddr;
        service       = srv;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            data_valid  = 1'b1;
            memory_data = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            data_valid  = 1'b0;
            memory_data = 16'($urandom);
        end
        if (r) begin
            m_busy = 1'b0;
            exp_q.delete();
        end
        e_req  = m_busy && (m_issued < BW);
        e_addr = e_req ? (m_base + 16'(2 * m_issued)) : 16'h0000;
        e_wr   = m_busy && data_valid && (exp_q.size() > 0);
        e_ws   = e_wr ? exp_q[0][2:0] : 3'd0;
        e_tag  = e_wr && (m_written == BW - 1);
        @(negedge clk);
        check("request", request, e_req);
        check("mem_address", mem_address, e_addr);
        check("fsm_busy", fsm_busy, m_busy);
        check("write_data_array", write_data_array, e_wr);
        check("word_sel", word_sel, e_ws);
        check("write_tag_array", write_tag_array, e_tag);
        check("fill_data", fill_data, r ? 16'h0000 : memory_data);
        if (fsm_busy) cnt_busy++;
        if (write_data_array) cnt_wr++;
        if (request && service) begin
            rd.due  = cyc + $urandom_range(lat_lo, lat_hi);
            rd.addr = mem_address;
            mem_q.push_back(rd);
        end
        if (!r) begin
            if (m_busy) begin
                if (e_req && srv) begin
                    exp_q.push_back(16'(m_issued));
                    m_issued++;
                end
                if (e_wr) begin
                    void'(exp_q.pop_front());
                    m_written++;
                    if (m_written == BW) m_busy = 1'b0;
                end
            end else if (miss) begin
                m_busy    = 1'b1;
                m_base    = maddr & 16'hFFF0;
                m_issued  = 0;
                m_written = 0;
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_idle(input logic srv_always);
        for (int k = 0; k < 200 && m_busy; k++) begin
            step(1'b0, 1'b0, 16'h0000, srv_always);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t v;
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0000;
        service       = 1'b0;
        data_valid    = 1'b0;
        memory_data   = 16'h0000;

        v = '0; v.rst = 1'b1; v.mdata = 16'h1111;
        vecs[0] = v;
        v = '0; v.mdata = 16'h2222; v.e_fd = 16'h2222;
        vecs[1] = v;
        // Basic fill of 0x1236, 4-cycle memory, continuous service, then a
        // spurious data_valid in IDLE.
        for (int k = 0; k < 15; k++) begin
            v        = '0;
            v.miss   = (k == 0);
            v.maddr  = (k == 0) ? 16'h1236 : 16'h0000;
            v.srv    = 1'b1;
            v.mdata  = 16'hC000 + 16'(k);
            v.dv     = (k >= 5 && k <= 13);
            v.e_req  = (k >= 1 && k <= 8);
            v.e_addr = v.e_req ? (16'h1230 + 16'(2 * (k - 1))) : 16'h0000;
            v.e_busy = (k >= 1 && k <= 12);
            v.e_wr   = (k >= 5 && k <= 12);
            v.e_ws   = v.e_wr ? 3'(k - 5) : 3'd0;
            v.e_tag  = (k == 12);
            v.e_fd   = v.mdata;
            vecs[k + 2] = v;
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            rst           = vecs[i].rst;
            miss_detected = vecs[i].miss;
            miss_address  = vecs[i].maddr;
            service       = vecs[i].srv;
            data_valid    = vecs[i].dv;
            memory_data   = vecs[i].mdata;
            @(negedge clk);
            check("tbl_request", request, vecs[i].e_req);
            check("tbl_mem_address", mem_address, vecs[i].e_addr);
            check("tbl_fsm_busy", fsm_busy, vecs[i].e_busy);
            check("tbl_write_data_array", write_data_array, vecs[i].e_wr);
            check("tbl_word_sel", word_sel, vecs[i].e_ws);
            check("tbl_write_tag_array", write_tag_array, vecs[i].e_tag);
            check("tbl_fill_data", fill_data, vecs[i].e_fd);
            @(posedge clk);
            #1;
        end

        // Grant stall: service withdrawn for 3 cycles after the 2nd grant.
        cnt_busy = 0; cnt_wr = 0;
        step(1'b0, 1'b1, 16'h1236, 1'b1);
        for (int k = 1; k <= 60 && m_busy; k++) begin
            step(1'b0, 1'b0, 16'h0000, !(k >= 3 && k <= 5));
        end
        check("stall_busy_cycles", cnt_busy, 15);
        check("stall_writes", cnt_wr, 8);

        // Re-miss while filling must not relatch the block.
        cnt_busy = 0; cnt_wr = 0;
        step(1'b0, 1'b1, 16'h1236, 1'b1);
        for (int k = 1; k <= 60 && m_busy; k++) begin
            step(1'b0, (k == 3 || k == 9), 16'hABC0, 1'b1);
        end
        check("remiss_busy_cycles", cnt_busy, 12);
        check("remiss_writes", cnt_wr, 8);

        // Reset after 5 grants; stale returns must not write.
        step(1'b0, 1'b1, 16'h1236, 1'b1);
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        cnt_busy = 0; cnt_wr = 0;
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        check("post_reset_writes", cnt_wr, 0);
        check("post_reset_busy", cnt_busy, 0);
        cnt_busy = 0; cnt_wr = 0;
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        run_to_idle(1'b1);
        check("refill_busy_cycles", cnt_busy, 12);
        check("refill_writes", cnt_wr, 8);

        // Back-to-back: new miss in the first IDLE cycle after the tag write.
        step(1'b0, 1'b1, 16'h2000, 1'b1);
        run_to_idle(1'b1);
        cnt_busy = 0; cnt_wr = 0;
        step(1'b0, 1'b1, 16'h3002, 1'b1);
        check("b2b_request", request, 1'b1);
        run_to_idle(1'b1);
        check("b2b_busy_cycles", cnt_busy, 12);
        check("b2b_writes", cnt_wr, 8);

        // Randomized fills with random latency, service gaps and miss noise.
        lat_lo = 1;
        lat_hi = 6;
        for (int f = 0; f < 25; f++) begin
            logic [15:0] a;
            int          idle;
            a    = 16'($urandom);
            idle = $urandom_range(0, 3);
            for (int k = 0; k < idle; k++) begin
                step(1'b0, 1'b0, 16'($urandom), 1'($urandom));
            end
            cnt_wr = 0;
            step(1'b0, 1'b1, a, 1'($urandom));
            for (int k = 0; k < 200 && m_busy; k++) begin
                step(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
            end
            check("rand_fill_writes", cnt_wr, 8);
            check("rand_fill_done", fsm_busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL provide parameter BLOCK_WORDS, default 8, meaning 16-bit words per cache block (16-byte block).
REQ-002 SHALL provide parameter ADDR_W, default 16, meaning byte-address width.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port miss_detected  input  1  cache lookup missed this cycle.
REQ-006 SHALL provide port miss_address  input  16  byte address of the missing access.
REQ-007 SHALL provide port service  input  1  grant from the memory arbitrator; a request is accepted in a cycle where request and service are both high.
REQ-008 SHALL provide port data_valid  input  1  read data for this port is on memory_data; qualified upstream, so it is never asserted for another port's reads.
REQ-009 SHALL provide port memory_data  input  16  read data from memory.
REQ-010 SHALL provide port request  output  1  read request to the arbitrator.
REQ-011 SHALL provide port mem_address  output  16  word address of the current request.
REQ-012 SHALL provide port fsm_busy  output  1  fill in progress; the cache stalls its pipeline while high.
REQ-013 SHALL provide port write_data_array  output  1  write fill_data into the data array this cycle.
REQ-014 SHALL provide port word_sel  output  3  word index within the block for write_data_array.
REQ-015 SHALL provide port fill_data  output  16  data to write; equals memory_data.
REQ-016 SHALL provide port write_tag_array  output  1  one-cycle pulse that writes the tag and sets the valid bit.

Function
REQ-017 SHALL have two states, IDLE and FILL, held in a register.
REQ-018 SHALL move IDLE->FILL on the clock edge where miss_detected=1, and SHALL latch base = miss_address[15:4] on that edge.
REQ-019 SHALL ignore miss_detected while in FILL (no relatch, no restart).
REQ-020 SHALL drive fsm_busy=1 exactly while state=FILL (registered; first high cycle is the cycle after miss_detected).
REQ-021 SHALL keep issue_cnt (0..8) and recv_cnt (0..8); both SHALL clear on entry to FILL.
REQ-022 SHALL drive request=1 while in FILL with issue_cnt<8; otherwise request=0.
REQ-023 SHALL drive mem_address={base, issue_cnt[2:0], 1'b0} while request=1; otherwise 16'h0000.
REQ-024 SHALL increment issue_cnt only on request&service, one word per cycle; a withdrawn service SHALL hold issue_cnt and the address stable.
REQ-025 SHALL treat data_valid in FILL with recv_cnt<issue_cnt as a received word; in that cycle it SHALL combinationally assert write_data_array=1, word_sel=recv_cnt[2:0] and fill_data=memory_data, and recv_cnt SHALL increment.
REQ-026 SHALL ignore data_valid in IDLE, or when recv_cnt=issue_cnt, with no array write.
REQ-027 SHALL allow an issue and a receive in the same cycle; both counters SHALL update independently.
REQ-028 SHALL assert write_tag_array=1 in the same cycle as the received word with recv_cnt=7, and SHALL move FILL->IDLE on that edge.
REQ-029 SHALL make the total fill latency from the miss edge to the IDLE return equal to 8 grants plus memory latency; with a 4-cycle memory and continuous service it SHALL be 12 cycles.
REQ-030 SHALL ensure a miss_detected in the first IDLE cycle after a fill starts a new fill.
REQ-031 SHALL keep write_data_array, write_tag_array and word_sel at 0 whenever no word is received.

Reset
REQ-032 SHALL, on rst=1 at any time (including mid-fill), immediately set state=IDLE, issue_cnt=0, recv_cnt=0 and base=0.
REQ-033 SHALL drive all outputs to 0 during reset: request, fsm_busy, write_data_array, write_tag_array, word_sel, mem_address, and fill_data (fill_data is gated to 0 while in reset).
REQ-034 SHALL, after reset deasserts mid-fill, discard later data_valid pulses (REQ-026) and not write the arrays.

Verification
REQ-035 SHALL cover a basic fill: miss_address=16'h1236, service held at 1, 4-cycle memory -> request addresses 0x1230,0x1232,...,0x123E on consecutive cycles; 8 writes with word_sel 0..7; write_tag_array on the 8th; fsm_busy high for 12 cycles.
REQ-036 SHALL cover grant stall: service=0 for 3 cycles after the 2nd grant -> mem_address holds at 0x1234, issue_cnt holds, and the fill completes with exactly 8 writes in order.
REQ-037 SHALL cover a spurious data_valid in IDLE -> no write_data_array and no state change.
REQ-038 SHALL cover re-miss in FILL: miss_detected with 16'hABC0 mid-fill -> addresses stay in block 0x123x.
REQ-039 SHALL cover reset mid-fill: rst pulse after 5 grants -> all outputs 0 at once; later data_valid pulses cause no writes; the next miss 16'h0040 fills 0x0040..0x004E.
REQ-040 SHALL cover back-to-back misses: miss_detected in the first IDLE cycle after write_tag_array -> a new fill starts and request is asserted the following cycle.
